// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative RV32M multiply/divide execute unit. Radix-2
//                shift-add multiply and restoring divide, one bit per cycle,
//                with a single sign-fixup cycle and a valid/ready result port.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int RAW  = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [RAW-1:0]  rd_addr,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [RAW-1:0]  out_rd,
    output logic            out_wen
);

    localparam int CW = $clog2(XLEN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CW-1:0]   c_LAST    = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] c_ONES    = '1;
    localparam logic [XLEN-1:0] c_INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [2:0]      r_op;
    logic [RAW-1:0]  r_rd;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_acc;      // product high half / partial remainder
    logic [XLEN-1:0] r_lo;       // multiplier then product low half / dividend then quotient
    logic [XLEN-1:0] r_opnd;     // multiplicand or divisor magnitude
    logic            r_neg;      // negate product or quotient in FIX
    logic            r_rem_neg;  // remainder takes the dividend's sign
    logic [XLEN-1:0] r_result;

    // Operand decode at issue
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_div_zero;
    logic            w_div_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;
    logic            w_accept;

    assign w_a_signed = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    assign w_b_signed = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    assign w_a_neg    = w_a_signed && rs1_val[XLEN-1];
    assign w_b_neg    = w_b_signed && rs2_val[XLEN-1];
    assign w_a_mag    = w_a_neg ? (~rs1_val + 1'b1) : rs1_val;
    assign w_b_mag    = w_b_neg ? (~rs2_val + 1'b1) : rs2_val;

    // Divide-by-zero and signed overflow bypass the iterative datapath
    assign w_div_zero    = op[2] && (rs2_val == '0);
    assign w_div_ovf     = ((op == 3'd4) || (op == 3'd6)) &&
                           (rs1_val == c_INT_MIN) && (rs2_val == c_ONES);
    assign w_special     = w_div_zero || w_div_ovf;
    assign w_special_res = w_div_zero ? (op[1] ? rs1_val : c_ONES)
                                      : (op[1] ? '0 : c_INT_MIN);

    assign w_accept = in_valid && (r_state == S_IDLE) && !kill;

    // Iteration datapath
    logic [XLEN:0]   w_msum;
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_diff;
    logic            w_ge;

    assign w_msum  = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_opnd} : '0);
    assign w_shift = {r_acc, r_lo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_opnd};
    assign w_ge    = !w_diff[XLEN];

    // Sign fixup and result selection
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_quo_s;
    logic [XLEN-1:0]   w_rem_s;
    logic [XLEN-1:0]   w_fix_res;

    assign w_prod   = {r_acc, r_lo};
    assign w_prod_s = r_neg ? (~w_prod + 1'b1) : w_prod;
    assign w_quo_s  = r_neg ? (~r_lo + 1'b1) : r_lo;
    assign w_rem_s  = r_rem_neg ? (~r_acc + 1'b1) : r_acc;

    // Pick the architectural result for the latched funct3
    always_comb begin
        w_fix_res = '0;
        case (r_op)
            3'd0:                   w_fix_res = w_prod_s[XLEN-1:0];
            3'd1, 3'd2, 3'd3:       w_fix_res = w_prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:             w_fix_res = w_quo_s;
            default:                w_fix_res = w_rem_s;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; kill overrides everything
    always_comb begin
        w_state_nxt = r_state;
        if (kill) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) w_state_nxt = w_special ? S_DONE : S_CALC;
                S_CALC: if (r_cnt == c_LAST) w_state_nxt = S_FIX;
                S_FIX:  w_state_nxt = S_DONE;
                S_DONE: if (out_ready) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
        out_wen   = (r_state == S_DONE) && (r_rd != '0);
    end

    assign result = r_result;
    assign out_rd = r_rd;

    // Operand capture, per-cycle multiply/divide step and result fixup
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op      <= '0;
            r_rd      <= '0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_lo      <= '0;
            r_opnd    <= '0;
            r_neg     <= 1'b0;
            r_rem_neg <= 1'b0;
            r_result  <= '0;
        end else if (kill) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op      <= op;
                        r_rd      <= rd_addr;
                        r_cnt     <= '0;
                        r_acc     <= '0;
                        r_neg     <= w_a_neg ^ w_b_neg;
                        r_rem_neg <= w_a_neg;
                        // Multiply walks the multiplier in r_lo; divide shifts the dividend out of it
                        r_lo      <= op[2] ? w_a_mag : w_b_mag;
                        r_opnd    <= op[2] ? w_b_mag : w_a_mag;
                        if (w_special) begin
                            r_result <= w_special_res;
                        end
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_op[2]) begin
                        r_acc <= w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
                        r_lo  <= {r_lo[XLEN-2:0], w_ge};
                    end else begin
                        r_acc <= w_msum[XLEN:1];
                        r_lo  <= {w_msum[0], r_lo[XLEN-1:1]};
                    end
                end
                S_FIX: begin
                    r_result <= w_fix_res;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Scoreboard bench for muldiv_unit. Stimulus pushes expected
//                result/rd/latency; a monitor compares on out_valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    localparam int XLEN = 32;
    localparam int RAW  = 5;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      op = '0;
    logic [XLEN-1:0] rs1_val = '0;
    logic [XLEN-1:0] rs2_val = '0;
    logic [RAW-1:0]  rd_addr = '0;
    logic            kill = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] result;
    logic [RAW-1:0]  out_rd;
    logic            out_wen;

    muldiv_unit #(.XLEN(XLEN), .RAW(RAW)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .rs1_val  (rs1_val),
        .rs2_val  (rs2_val),
        .rd_addr  (rd_addr),
        .kill     (kill),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .out_rd   (out_rd),
        .out_wen  (out_wen)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   rdy_mode = 0;   // 0 random, 1 hold low, 2 hold high

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model straight from the RV32M definitions
    function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub, p;
        int          ia, ib;
        logic [63:0] pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        ia = $signed(a);
        ib = $signed(b);
        case (o)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(ia / ib);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o[2] && b == 0) return 0;
        if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return XLEN + 1;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // out_ready driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: out_ready = 1'b0;
                2: out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: compare every presented result against the queue head
    logic seen = 1'b0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (!reset) begin
            seen = 1'b0;
        end else if (out_valid) begin
            if (sb_q.size() == 0) begin
                chk("spurious_out_valid", 64'(out_valid), 64'd0);
            end else begin
                mon_e = sb_q[0];
                if (!seen) begin
                    chk("latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
                    seen = 1'b1;
                end
                chk("result", 64'(result), 64'(mon_e.res));
                chk("out_rd", 64'(out_rd), 64'(mon_e.rd));
                chk("out_wen", 64'(out_wen), 64'(mon_e.rd != 0));
                chk("in_ready_busy", 64'(in_ready), 64'd0);
                if (out_ready) begin
                    void'(sb_q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit track);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("issue_timeout", 64'd0, 64'd1);
            return;
        end
        op = o; rs1_val = a; rs2_val = b; rd_addr = rd; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (track) begin
            e.res = ref_res(o, a, b);
            e.rd  = rd;
            e.lat = ref_lat(o, a, b);
            e.acc = cyc;
            sb_q.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) chk("drain_timeout", 64'(sb_q.size()), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit saw;
        int n;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_out_rd", 64'(out_rd), 64'd0);
        chk("rst_out_wen", 64'(out_wen), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        reset = 1'b1;

        // Directed corner values
        issue(3'd0, 32'd7,          32'hFFFF_FFFD, 5'd3,  1);
        issue(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd4,  1);
        issue(3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd5,  1);
        issue(3'd2, 32'hFFFF_FFFF,  32'd2,         5'd6,  1);
        issue(3'd4, 32'hFFFF_FFF9,  32'd2,         5'd7,  1);
        issue(3'd6, 32'hFFFF_FFF9,  32'd2,         5'd8,  1);
        issue(3'd5, 32'd100,        32'd7,         5'd9,  1);
        issue(3'd7, 32'd100,        32'd7,         5'd10, 1);
        issue(3'd5, 32'd5,          32'd0,         5'd11, 1);
        issue(3'd6, 32'd5,          32'd0,         5'd12, 1);
        issue(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 1);
        issue(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 1);
        drain();

        // Held result with rd=0, then release
        rdy_mode = 1;
        issue(3'd5, 32'd100, 32'd7, 5'd0, 1);
        n = 0;
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        rdy_mode = 2;
        drain();
        chk("idle_after_handshake", 64'(in_ready), 64'd1);

        // Randomized traffic
        rdy_mode = 0;
        repeat (40) begin
            logic [31:0] a, b;
            a = pick();
            b = pick();
            issue(3'($urandom_range(0, 7)), a, b, 5'($urandom_range(0, 31)), 1);
        end
        drain();

        // kill mid-CALC
        rdy_mode = 2;
        issue(3'd5, 32'd1000, 32'd3, 5'd9, 0);
        repeat (15) @(posedge clk);
        #1 kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        chk("kill_in_ready", 64'(in_ready), 64'd1);
        chk("kill_out_valid", 64'(out_valid), 64'd0);
        saw = 1'b0;
        repeat (40) begin @(negedge clk); saw |= out_valid; end
        chk("kill_no_out_valid", 64'(saw), 64'd0);

        // kill together with in_valid in IDLE blocks acceptance
        @(negedge clk);
        op = 3'd0; rs1_val = 32'd3; rs2_val = 32'd4; rd_addr = 5'd1;
        in_valid = 1'b1; kill = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; kill = 1'b0;
        chk("kill_blocks_accept", 64'(in_ready), 64'd1);

        // Asynchronous reset mid-CALC
        issue(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd17, 0);
        repeat (20) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_result", 64'(result), 64'd0);
        chk("arst_out_rd", 64'(out_rd), 64'd0);
        chk("arst_out_wen", 64'(out_wen), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        issue(3'd1, 32'h8000_0000, 32'h7FFF_FFFF, 5'd18, 1);
        issue(3'd7, 32'hDEAD_BEEF, 32'd1000, 5'd19, 1);
        drain();

        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
